// File: rtl/slot_pkg.sv
// rtl/slot_pkg.sv - shared slot constants, state enum and index decode
package slot_pkg;

  localparam int SLOTS = 12;
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] ALIAS_IDX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  // Indices 12..15 fall back to the same slot the read mux defaults to.
  function automatic logic [SLOTS-1:0] slot_onehot(input logic [IDX_W-1:0] idx);
    logic [SLOTS-1:0] oh;
    oh = '0;
    for (int s = 0; s < SLOTS; s++) begin
      oh[s] = (idx == IDX_W'(s));
    end
    if (idx >= IDX_W'(SLOTS)) begin
      oh[ALIAS_IDX] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/slot_reg.sv
// rtl/slot_reg.sv - N-bit slot register with clear and write enable
module slot_reg #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         we,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/slot_loader_12.sv
// rtl/slot_loader_12.sv - scatters a word stream into twelve slot registers
module slot_loader_12
  import slot_pkg::*;
#(
  parameter int N = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             release_frame,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             addr_mode,
  input  logic [IDX_W-1:0] addr,
  output logic [N-1:0]     a,
  output logic [N-1:0]     b,
  output logic [N-1:0]     c,
  output logic [N-1:0]     d,
  output logic [N-1:0]     e,
  output logic [N-1:0]     f,
  output logic [N-1:0]     g,
  output logic [N-1:0]     h,
  output logic [N-1:0]     i,
  output logic [N-1:0]     j,
  output logic [N-1:0]     k,
  output logic [N-1:0]     l,
  output logic [IDX_W-1:0] ptr,
  output logic             full,
  output logic             frame_done
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr_nxt;
  logic             done_nxt;
  logic             wr_any;
  logic             clr_slots;
  logic [IDX_W-1:0] wr_idx;
  logic [SLOTS-1:0] wr_en;
  logic [N-1:0]     q [SLOTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      frame_done <= done_nxt;
    end
  end

  // clear outranks commands, commands outrank the handshake
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    wr_any    = 1'b0;
    clr_slots = 1'b0;
    wr_idx    = ptr;
    if (clear) begin
      state_nxt = IDLE;
      ptr_nxt   = '0;
      clr_slots = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = FILL;
            ptr_nxt   = '0;
          end
        end
        FILL: begin
          if (in_valid) begin
            wr_any = 1'b1;
            if (addr_mode) begin
              wr_idx = addr;
            end else if (ptr == IDX_W'(SLOTS - 1)) begin
              ptr_nxt   = '0;
              state_nxt = FULL;
              done_nxt  = 1'b1;
            end else begin
              ptr_nxt = ptr + 1'b1;
            end
          end
        end
        FULL: begin
          if (release_frame) begin
            state_nxt = FILL;
            ptr_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end
      endcase
    end
  end

  assign wr_en    = wr_any ? slot_onehot(wr_idx) : '0;
  assign in_ready = (state == FILL);
  assign full     = (state == FULL);

  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    slot_reg #(.N(N)) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr_slots),
      .we   (wr_en[s]),
      .d    (in_data),
      .q    (q[s])
    );
  end

  assign a = q[0];
  assign b = q[1];
  assign c = q[2];
  assign d = q[3];
  assign e = q[4];
  assign f = q[5];
  assign g = q[6];
  assign h = q[7];
  assign i = q[8];
  assign j = q[9];
  assign k = q[10];
  assign l = q[11];

endmodule

// File: tb/tb_slot_loader_12.sv
// tb/tb_slot_loader_12.sv - directed vector bench for slot_loader_12
module tb_slot_loader_12;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n, start, clear, release_frame, in_valid, addr_mode;
  logic         in_ready, full, frame_done;
  logic [N-1:0] in_data;
  logic [3:0]   addr, ptr;
  logic [N-1:0] a, b, c, d, e, f, g, h, i, j, k, l;
  logic [N-1:0] sl [12];

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  slot_loader_12 #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .release_frame(release_frame), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .addr_mode(addr_mode), .addr(addr),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .i(i), .j(j), .k(k), .l(l),
    .ptr(ptr), .full(full), .frame_done(frame_done)
  );

  assign sl[0] = a;  assign sl[1] = b;  assign sl[2]  = c;  assign sl[3]  = d;
  assign sl[4] = e;  assign sl[5] = f;  assign sl[6]  = g;  assign sl[7]  = h;
  assign sl[8] = i;  assign sl[9] = j;  assign sl[10] = k;  assign sl[11] = l;

  typedef struct {
    logic       st, cl, rel, vld, am;
    logic [3:0] ad;
    logic [4:0] dat;
    logic [3:0] e_ptr;
    logic       e_full, e_rdy, e_done;
    int         e_idx;
    logic [4:0] e_val;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic cl, logic rel, logic vld, logic am,
                              logic [3:0] ad, logic [4:0] dat, logic [3:0] e_ptr,
                              logic e_full, logic e_rdy, logic e_done,
                              int e_idx, logic [4:0] e_val);
    vec_t v;
    v.st = st; v.cl = cl; v.rel = rel; v.vld = vld; v.am = am; v.ad = ad;
    v.dat = dat; v.e_ptr = e_ptr; v.e_full = e_full; v.e_rdy = e_rdy;
    v.e_done = e_done; v.e_idx = e_idx; v.e_val = e_val;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic idle_in();
    start = 0; clear = 0; release_frame = 0; in_valid = 0;
    addr_mode = 0; addr = 0; in_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic seq_word(logic [4:0] v);
    idle_in(); in_valid = 1; in_data = v; step();
  endtask

  int acc, done_cnt, cyc;
  logic rdy_now;

  initial begin
    idle_in();
    rst_n = 0;
    #12;
    check("rst_ptr", ptr, 0);
    check("rst_ready", in_ready, 0);
    check("rst_full", full, 0);
    check("rst_done", frame_done, 0);
    check("rst_a", a, 0);
    check("rst_l", l, 0);
    @(negedge clk);
    rst_n = 1;
    step();

    // directed table: applied one vector per cycle, checked after the edge
    tbl.push_back(mk(0,0,0,1,0,0,5'd9, 0,0,0,0, 0,0));   // valid in IDLE ignored
    tbl.push_back(mk(1,0,0,0,0,0,0,    0,0,1,0, 0,0));
    for (int w = 1; w <= 12; w++)
      tbl.push_back(mk(0,0,0,1,0,0,5'(w), 4'(w % 12), w == 12, w != 12, w == 12, w - 1, 5'(w)));
    tbl.push_back(mk(1,0,0,1,0,0,5'd31, 0,1,0,0, 0,5'd1));  // FULL: beat and start ignored
    tbl.push_back(mk(0,0,1,0,0,0,0,     0,0,1,0, 11,5'd12));
    tbl.push_back(mk(1,0,0,1,0,0,5'd7,  1,0,1,0, 0,5'd7));  // start ignored in FILL
    tbl.push_back(mk(0,0,0,1,1,4'd4,5'd21, 1,0,1,0, 4,5'd21));
    tbl.push_back(mk(0,0,0,1,1,4'd14,5'd3, 1,0,1,0, 9,5'd3));
    tbl.push_back(mk(0,0,0,0,0,0,0,     1,0,1,0, 1,5'd2));
    tbl.push_back(mk(0,0,0,0,0,0,0,     1,0,1,0, 4,5'd21));
    tbl.push_back(mk(0,0,0,1,1,4'd11,5'd17, 1,0,1,0, 11,5'd17));

    foreach (tbl[n]) begin
      start = tbl[n].st; clear = tbl[n].cl; release_frame = tbl[n].rel;
      in_valid = tbl[n].vld; addr_mode = tbl[n].am; addr = tbl[n].ad;
      in_data = tbl[n].dat;
      step();
      check($sformatf("v%0d_ptr", n), ptr, tbl[n].e_ptr);
      check($sformatf("v%0d_full", n), full, tbl[n].e_full);
      check($sformatf("v%0d_ready", n), in_ready, tbl[n].e_rdy);
      check($sformatf("v%0d_done", n), frame_done, tbl[n].e_done);
      check($sformatf("v%0d_slot%0d", n, tbl[n].e_idx), sl[tbl[n].e_idx], tbl[n].e_val);
    end
    check("tbl_c_kept", c, 3);
    check("tbl_j_alias", j, 3);

    // four more sequential words take ptr to 5, then clear with a live beat
    seq_word(5'd20); seq_word(5'd21); seq_word(5'd22); seq_word(5'd23);
    check("pre_clr_ptr", ptr, 5);
    check("pre_clr_d", d, 22);
    idle_in(); clear = 1; in_valid = 1; in_data = 5'd30;
    step();
    idle_in();
    check("clr_ptr", ptr, 0);
    check("clr_ready", in_ready, 0);
    check("clr_full", full, 0);
    for (int s = 0; s < 12; s++) check($sformatf("clr_slot%0d", s), sl[s], 0);
    step();
    check("clr_idle_ready", in_ready, 0);

    // asynchronous reset mid-frame
    start = 1; step(); idle_in();
    seq_word(5'd4); seq_word(5'd5); seq_word(5'd6);
    check("prerst_c", c, 6);
    #3;
    rst_n = 0;
    #1;
    check("arst_a", a, 0);
    check("arst_c", c, 0);
    check("arst_ptr", ptr, 0);
    check("arst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1;
    in_valid = 1; in_data = 5'd8;
    step(); step();
    check("postrst_ready", in_ready, 0);
    check("postrst_a", a, 0);
    idle_in();

    // random valid over one frame
    start = 1; step(); idle_in();
    acc = 0; done_cnt = 0; cyc = 0;
    while (acc < 12 && cyc < 300) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 5'(10 + acc);
      rdy_now = in_ready;
      step();
      cyc++;
      if (in_valid && rdy_now) acc++;
      if (frame_done) done_cnt++;
    end
    check("rnd_accepts", acc, 12);
    check("rnd_done_at_12", frame_done, 1);
    idle_in();
    in_valid = 1; in_data = 5'd1;
    for (int x = 0; x < 3; x++) begin
      step();
      if (frame_done) done_cnt++;
    end
    idle_in();
    check("rnd_done_count", done_cnt, 1);
    check("rnd_full", full, 1);
    for (int s = 0; s < 12; s++) check($sformatf("rnd_slot%0d", s), sl[s], 10 + s);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/slot_loader_12.md
# slot_loader_12

Write-side counterpart of the 12-input slot select mux: accepts a stream of N-bit words over a valid/ready handshake and scatters them into twelve N-bit slot registers (slots a..l, indices 0..11). The slot registers feed the 12:1 read mux directly. The block supports sequential frame filling with an auto-incrementing pointer and single addressed writes. It signals when a full 12-word frame has been loaded.

## Interface
- N, default 5: word width of every slot and of in_data
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  IDLE→FILL, pointer to 0
- clear  in  1  synchronous clear of all slots and pointer, state to IDLE
- release_frame  in  1  FULL→FILL, pointer to 0, slot contents retained
- in_valid  in  1  word present on in_data
- in_ready  out  1  block can accept a word this cycle
- in_data  in  N  word to store
- addr_mode  in  1  0 = sequential write at pointer; 1 = write at addr
- addr  in  4  target slot index when addr_mode=1
- a, b, c, d, e, f, g, h, i, j, k, l  out  N each  slot registers, index 0..11
- ptr  out  4  next sequential slot index, 0..11
- full  out  1  high while in FULL
- frame_done  out  1  one-cycle pulse when a frame completes

## Operation
- States: IDLE, FILL, FULL.
- IDLE: in_ready=0. start→FILL with ptr=0.
- FILL: in_ready=1. A beat is accepted when in_valid && in_ready.
  - addr_mode=0: write in_data to slot[ptr], then ptr+1. If ptr was 11, ptr wraps to 0, state→FULL and frame_done pulses.
  - addr_mode=1: write in_data to slot[addr]. ptr and state are unchanged. addr 12..15 aliases to slot 9 (j), the same default index the read mux uses.
- FULL: in_ready=0, full=1. release_frame→FILL with ptr=0.
- Priority, highest first: clear, then release_frame/start, then handshake.
  - Commands that are illegal in the current state are ignored: start outside IDLE, release_frame outside FULL.
  - clear in any state: all slots 0, ptr 0, state IDLE. Any beat presented that cycle is dropped.
- in_data is written unmodified. No width conversion. ptr arithmetic is 4-bit, mod 12.

## Timing
- Reset (rst_n low, asynchronous): all slots 0, ptr 0, state IDLE, in_ready 0, full 0, frame_done 0.
- in_ready and full are decoded combinationally from the state register.
- A slot write is visible on its output port the cycle after the accepting edge (1-cycle latency).
- frame_done is registered. It is high for exactly the one cycle after the edge that accepted the sequential write to slot 11, coincident with full rising.
- Throughput: one word per cycle in FILL. A 12-word frame takes 12 consecutive cycles. in_ready drops the cycle after the 12th accept.
- release_frame in the same cycle that FULL is entered: not possible. It is sampled only while in FULL.
- Deasserting rst_n mid-frame discards the partial frame. After rst_n rises the block restarts from IDLE.

## Structure
- Shared package slot_pkg:
  - SLOTS=12, IDX_W=4, ALIAS_IDX=4'd9
  - state enum {IDLE, FILL, FULL}
  - Both this block and the read mux import it.
- One sub-module is natural: slot_reg, an N-bit register with asynchronous active-low reset, synchronous clear, and write enable, instantiated twelve times.
- Write enables come from a 4→12 one-hot decode of the selected index (ptr or addr) qualified by the handshake, with the alias for indices 12..15.

## Test plan
- Reset then start, stream 12 words 1..12 back-to-back (addr_mode=0) → a..l = 1..12, frame_done high one cycle after the 12th accept, full=1, in_ready=0, ptr=0.
- In FULL, hold in_valid with data 31 → no slot changes. Pulse release_frame, then send 7 → a=7, b..l retained, ptr=1.
- In FILL, addr_mode=1, addr=4, data 21 → e=21, ptr unchanged. addr=14, data 3 → j=3, other slots unchanged.
- After 5 sequential words, assert clear together with in_valid → all slots 0, ptr 0, state IDLE, in_ready 0, beat not stored.
- Drop rst_n asynchronously between clock edges mid-frame → outputs 0 immediately. After release, in_ready stays 0 until start.
- Set in_valid randomly for a full frame → slots hold the accepted words in order, and frame_done fires once per 12 accepted sequential beats.
